// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and small-sigma helpers for the schedule and compression stages.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int SHA_ROUNDS  = 64;
  localparam int SCHED_WORDS = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-in / schedule-word-out bus of the SHA-256 message scheduler.
// SHA256_SCHED_STALL_EN adds the `advance` stall input.
interface sha256_msg_schedule_if #(
  parameter int CNT_W = 6
);
  import sha256_pkg::*;

  logic             start;
  logic [511:0]     block;
  word_t            wt;
  logic             wt_valid;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
`ifdef SHA256_SCHED_STALL_EN
  logic             advance;
`endif

  modport master (
    output start, block,
`ifdef SHA256_SCHED_STALL_EN
    output advance,
`endif
    input  wt, wt_valid, count, busy, done
  );

  modport slave (
    input  start, block,
`ifdef SHA256_SCHED_STALL_EN
    input  advance,
`endif
    output wt, wt_valid, count, busy, done
  );

endinterface

// File: rtl/sha256_sched_expand.sv
// Combinational expansion step: W[t] from W[t-16], W[t-15], W[t-7], W[t-2].
module sha256_sched_expand
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t w_new
);

  assign w_new = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: emits W[0..ROUNDS-1] one per cycle from a 512-bit block.
// Optional SHA256_SCHED_STALL_EN gates each RUN step with bus.advance.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA_ROUNDS,
  parameter int CNT_W  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  sha256_msg_schedule_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  sched_state_t     state_q;
  sched_state_t     state_d;
  word_t            win [SCHED_WORDS];
  word_t            new_word;
  logic [CNT_W-1:0] count_q;
  logic             step;
  logic             last;

`ifdef SHA256_SCHED_STALL_EN
  assign step = bus.advance;
`else
  assign step = 1'b1;
`endif

  assign last = (count_q == LAST);

  sha256_sched_expand u_expand (
    .w0    (win[0]),
    .w1    (win[1]),
    .w9    (win[9]),
    .w14   (win[14]),
    .w_new (new_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (step && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.wt_valid = (state_q == RUN);
    bus.busy     = (state_q == RUN);
    bus.done     = (state_q == DONE);
  end

  // win[0] is the oldest word and is exactly the word being presented
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SCHED_WORDS; i++) win[i] <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < SCHED_WORDS; i++) win[i] <= bus.block[511-32*i -: 32];
          end
          count_q <= '0;
        end
        RUN: begin
          if (step) begin
            for (int i = 0; i < SCHED_WORDS - 1; i++) win[i] <= win[i+1];
            win[SCHED_WORDS-1] <= new_word;
            count_q <= last ? '0 : count_q + 1'b1;
          end
        end
        default: count_q <= '0;
      endcase
    end
  end

  assign bus.wt    = win[0];
  assign bus.count = count_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule with a queue scoreboard of expected words.
module tb_sha256_msg_schedule;

  typedef struct {
    logic [5:0]  cnt;
    logic [31:0] w;
  } exp_t;

  localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   fresh = 1'b1;

  always #5 clk = ~clk;

  sha256_msg_schedule_if #(.CNT_W(6)) bus ();

  sha256_msg_schedule #(.ROUNDS(64), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic push_block(input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int t = 0; t < 64; t++) sb.push_back('{cnt: 6'(t), w: w[t]});
  endtask

  // Call at posedge+2; returns at posedge+2 just after the accepting edge.
  task automatic start_block(input logic [511:0] b);
    push_block(b);
    bus.start = 1'b1;
    bus.block = b;
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.block = ~b;
  endtask

  task automatic next_cycle();
    @(posedge clk); #2;
  endtask

  // Scoreboard monitor: pops one expected word per freshly presented valid word
  always @(negedge clk) begin
    if (bus.wt_valid && fresh) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got cnt=%0d wt=%h required no word", bus.count, bus.wt);
      end else begin
        mon_e = sb.pop_front();
        if (bus.wt !== mon_e.w || bus.count !== mon_e.cnt) begin
          bad++;
          $display("FAIL sb_word got cnt=%0d wt=%h required cnt=%0d wt=%h",
                   bus.count, bus.wt, mon_e.cnt, mon_e.w);
        end
      end
    end
`ifdef SHA256_SCHED_STALL_EN
    fresh = !bus.wt_valid || bus.advance;
`else
    fresh = 1'b1;
`endif
  end

  task automatic test_reset();
    reset = 1'b1;
    #3;
    total++; if (bus.wt !== 32'h0)    begin bad++; $display("FAIL rst_wt got %h required 0", bus.wt); end
    total++; if (bus.wt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b required 0", bus.wt_valid); end
    total++; if (bus.count !== 6'd0)  begin bad++; $display("FAIL rst_count got %0d required 0", bus.count); end
    total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got %b required 0", bus.busy); end
    total++; if (bus.done !== 1'b0)   begin bad++; $display("FAIL rst_done got %b required 0", bus.done); end
    next_cycle();
    reset = 1'b0;
    next_cycle();
    total++; if (bus.busy !== 1'b0 || bus.wt_valid !== 1'b0) begin
      bad++; $display("FAIL rst_idle got busy=%b valid=%b required 0 0", bus.busy, bus.wt_valid);
    end
  endtask

  task automatic test_abc();
    int k = 0;
    bit got = 0;
    next_cycle();
    start_block(ABC);
    while (!got && k < 100) begin
      if (k < 64) begin
        total++;
        if (bus.count !== 6'(k) || bus.wt_valid !== 1'b1 || bus.busy !== 1'b1) begin
          bad++; $display("FAIL abc_count got cnt=%0d valid=%b busy=%b required cnt=%0d 1 1",
                          bus.count, bus.wt_valid, bus.busy, k);
        end
      end
      if (k == 0)  begin total++; if (bus.wt !== 32'h61626380) begin bad++; $display("FAIL abc_w0 got %h required 61626380", bus.wt); end end
      if (k == 15) begin total++; if (bus.wt !== 32'h00000018) begin bad++; $display("FAIL abc_w15 got %h required 00000018", bus.wt); end end
      if (k == 16) begin total++; if (bus.wt !== 32'h61626380) begin bad++; $display("FAIL abc_w16 got %h required 61626380", bus.wt); end end
      if (k == 17) begin total++; if (bus.wt !== 32'h000F0000) begin bad++; $display("FAIL abc_w17 got %h required 000f0000", bus.wt); end end
      if (bus.done === 1'b1) begin
        got = 1;
        total++; if (k != 64) begin bad++; $display("FAIL abc_done_latency got %0d required 64", k); end
        total++; if (bus.count !== 6'd0 || bus.busy !== 1'b0 || bus.wt_valid !== 1'b0) begin
          bad++; $display("FAIL abc_done_outputs got cnt=%0d busy=%b valid=%b required 0 0 0",
                          bus.count, bus.busy, bus.wt_valid);
        end
      end else begin
        next_cycle();
        k++;
      end
    end
    total++; if (!got) begin bad++; $display("FAIL abc_done_timeout got no done required done"); end
    next_cycle();
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL abc_done_width got done=%b busy=%b required 0 0", bus.done, bus.busy);
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL abc_sb_left got %0d required 0", sb.size()); end
  endtask

  task automatic test_zero_block();
    int k = 0;
    int nvalid = 0;
    bit got = 0;
    next_cycle();
    start_block('0);
    while (!got && k < 100) begin
      if (bus.wt_valid === 1'b1) nvalid++;
      if (bus.done === 1'b1) got = 1;
      else begin next_cycle(); k++; end
    end
    total++; if (!got) begin bad++; $display("FAIL zero_done_timeout got no done required done"); end
    total++; if (nvalid != 64) begin bad++; $display("FAIL zero_valid_cycles got %0d required 64", nvalid); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL zero_sb_left got %0d required 0", sb.size()); end
  endtask

  task automatic test_restart_ignored();
    int ndone = 0;
    next_cycle();
    start_block(rand_block());
    for (int k = 0; k < 90; k++) begin
      if (k == 20) begin
        bus.start = 1'b1;
        bus.block = rand_block();
      end
      if (k == 21) begin
        bus.start = 1'b0;
        total++; if (bus.count !== 6'd21) begin bad++; $display("FAIL restart_count got %0d required 21", bus.count); end
      end
      if (bus.done === 1'b1) ndone++;
      next_cycle();
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL restart_done_pulses got %0d required 1", ndone); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL restart_sb_left got %0d required 0", sb.size()); end
  endtask

  task automatic test_reset_midblock();
    int k = 0;
    bit got = 0;
    next_cycle();
    start_block(ABC);
    while (k < 30) begin next_cycle(); k++; end
    total++; if (bus.count !== 6'd30) begin bad++; $display("FAIL midrst_pre_count got %0d required 30", bus.count); end
    #1 reset = 1'b1;
    #1;
    total++; if (bus.wt !== 32'h0 || bus.count !== 6'd0 || bus.wt_valid !== 1'b0 ||
                 bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got wt=%h cnt=%0d valid=%b busy=%b done=%b required all 0",
                      bus.wt, bus.count, bus.wt_valid, bus.busy, bus.done);
    end
    sb.delete();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got %b required 0", bus.done); end
    start_block(ABC);
    k = 0;
    while (!got && k < 100) begin
      if (bus.done === 1'b1) got = 1;
      else begin next_cycle(); k++; end
    end
    total++; if (!got || k != 64) begin bad++; $display("FAIL midrst_rerun_done got k=%0d required 64", k); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL midrst_sb_left got %0d required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] b2;
    int k = 0;
    bit got = 0;
    b2 = rand_block();
    next_cycle();
    start_block(rand_block());
    while (!got && k < 100) begin
      if (bus.done === 1'b1) got = 1;
      else begin next_cycle(); k++; end
    end
    total++; if (!got || k != 64) begin bad++; $display("FAIL b2b_first_done got k=%0d required 64", k); end
    // start presented during DONE must be dropped
    bus.start = 1'b1;
    bus.block = rand_block();
    next_cycle();
    total++; if (bus.busy !== 1'b0 || bus.wt_valid !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL b2b_done_start got busy=%b valid=%b done=%b required 0 0 0",
                      bus.busy, bus.wt_valid, bus.done);
    end
    start_block(b2);
    total++; if (bus.count !== 6'd0 || bus.wt !== b2[511:480] || bus.wt_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_second_first got cnt=%0d wt=%h valid=%b required 0 %h 1",
                      bus.count, bus.wt, bus.wt_valid, b2[511:480]);
    end
    got = 0; k = 0;
    while (!got && k < 100) begin
      if (bus.done === 1'b1) got = 1;
      else begin next_cycle(); k++; end
    end
    total++; if (!got || k != 64) begin bad++; $display("FAIL b2b_second_done got k=%0d required 64", k); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_sb_left got %0d required 0", sb.size()); end
  endtask

`ifdef SHA256_SCHED_STALL_EN
  task automatic test_stall();
    int k = 0;
    int nadv = 0;
    bit got = 0;
    logic [5:0]  p_cnt;
    logic [31:0] p_wt;
    logic        p_adv, p_valid;
    next_cycle();
    bus.advance = 1'b1;
    start_block(ABC);
    while (!got && k < 400) begin
      p_cnt = bus.count; p_wt = bus.wt; p_valid = bus.wt_valid;
      bus.advance = 1'($urandom_range(0, 1));
      p_adv = bus.advance;
      next_cycle();
      k++;
      if (p_valid && p_adv) nadv++;
      if (p_valid && !p_adv) begin
        total++;
        if (bus.count !== p_cnt || bus.wt !== p_wt || bus.wt_valid !== 1'b1) begin
          bad++; $display("FAIL stall_hold got cnt=%0d wt=%h valid=%b required %0d %h 1",
                          bus.count, bus.wt, bus.wt_valid, p_cnt, p_wt);
        end
      end
      if (bus.done === 1'b1) begin
        got = 1;
        total++; if (nadv != 64) begin bad++; $display("FAIL stall_done_adv got %0d required 64", nadv); end
      end
    end
    bus.advance = 1'b1;
    total++; if (!got) begin bad++; $display("FAIL stall_done_timeout got no done required done"); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL stall_sb_left got %0d required 0", sb.size()); end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.block = '0;
`ifdef SHA256_SCHED_STALL_EN
    bus.advance = 1'b1;
`endif
    test_reset();
    test_abc();
    test_zero_block();
    test_restart_ignored();
    test_reset_midblock();
    test_back_to_back();
`ifdef SHA256_SCHED_STALL_EN
    test_stall();
`endif
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
